// File: rtl/fetch_unit.sv
// Instruction fetch stage of the pierogi CPU.
//
// Holds the program counter, issues word reads to instruction memory over a
// req/ready handshake, latches the returned word into the instruction register
// and exposes its decoded fields. The PC advances when control signals that
// the current instruction has finished (ex_done), using jump_sel (M13) and
// take_branch (M2) to choose the next address.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall               suppresses the fetch request while high
//   imem_req/addr       read request and word address (addr == pc)
//   imem_ready/rdata    read completion and instruction word
//   ex_done             one-cycle pulse: current instruction finished
//   jump_sel            take absolute jump target when a redirect is taken
//   take_branch         redirect the PC instead of falling through
//   pc, pc_plus1        address of the instruction in ir, and pc+1
//   ir                  instruction register
//   opcode/rd/rs/rt/imm decoded fields of ir
//   instr_valid         ir holds a fetched, not yet completed instruction
//   instr_count         completed-instruction counter (wraps)
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              ex_done,
  input  logic              jump_sel,
  input  logic              take_branch,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [31:0]       ir,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [15:0]       imm,
  output logic              instr_valid,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              valid_q, valid_d;
  logic [31:0]       count_q, count_d;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] next_pc;

  // Wide intermediates let the extensions work for any ADDR_W, including
  // widths narrower than the 28-bit jump field.
  logic [ADDR_W+27:0] jump_wide;
  logic [ADDR_W+15:0] imm_wide;

  assign pc_inc        = pc_q + ADDR_W'(1);
  assign jump_wide     = {{ADDR_W{1'b0}}, ir_q[27:0]};
  assign imm_wide      = {{ADDR_W{ir_q[15]}}, ir_q[15:0]};
  assign jump_target   = jump_wide[ADDR_W-1:0];
  assign branch_target = pc_inc + imm_wide[ADDR_W-1:0];

  always_comb begin
    next_pc = pc_inc;
    if (take_branch) begin
      next_pc = jump_sel ? jump_target : branch_target;
    end
  end

  // Request depends only on state and stall, so reset kills it at once.
  assign imem_req = (state_q == StFetch) && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        // ready is only honoured together with a live request.
        if (imem_req && imem_ready) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        if (ex_done) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus1    = pc_inc;
  assign ir          = ir_q;
  assign opcode      = ir_q[31:28];
  assign rd          = ir_q[27:24];
  assign rs          = ir_q[23:20];
  assign rt          = ir_q[19:16];
  assign imm         = ir_q[15:0];
  assign instr_valid = valid_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. A second instance with an
// 8-bit PC reset to all-ones covers PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, ex_done, jump_sel, take_branch;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc, pc_plus1, ir, instr_count;
  logic [3:0]  opcode, rd, rs, rt;
  logic [15:0] imm;

  logic        w_reset, w_stall, w_ready, w_ex_done, w_jump_sel, w_take_branch;
  logic [31:0] w_rdata;
  logic        w_req, w_valid;
  logic [7:0]  w_addr, w_pc, w_pc_plus1;
  logic [31:0] w_ir, w_count;
  logic [3:0]  w_opcode, w_rd, w_rs, w_rt;
  logic [15:0] w_imm;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ex_done(ex_done), .jump_sel(jump_sel), .take_branch(take_branch),
    .pc(pc), .pc_plus1(pc_plus1), .ir(ir),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .instr_valid(instr_valid), .instr_count(instr_count)
  );

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) u_wrap (
    .clk(clk), .reset(w_reset), .stall(w_stall),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata),
    .ex_done(w_ex_done), .jump_sel(w_jump_sel), .take_branch(w_take_branch),
    .pc(w_pc), .pc_plus1(w_pc_plus1), .ir(w_ir),
    .opcode(w_opcode), .rd(w_rd), .rs(w_rs), .rt(w_rt), .imm(w_imm),
    .instr_valid(w_valid), .instr_count(w_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    ex_done = 1'b0; jump_sel = 1'b0; take_branch = 1'b0;
    w_reset = 1'b1; w_stall = 1'b0; w_ready = 1'b0; w_rdata = 32'd0;
    w_ex_done = 1'b0; w_jump_sel = 1'b0; w_take_branch = 1'b0;

    // Reset held for 3 cycles.
    tick(); tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_fields", {opcode, rd, rs, rt, imm}, 32'd0);

    // Release: IDLE cycle, then first request with addr 0.
    reset = 1'b0;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("fetch0_req", {31'd0, imem_req}, 32'd1);
    check("fetch0_addr", imem_addr, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'h4123_0000;
    tick();
    check("cap0_ir", ir, 32'h4123_0000);
    check("cap0_fields", {16'd0, opcode, rd, rs, rt}, 32'h0000_4123);
    check("cap0_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b0; ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    check("fetch1_addr", imem_addr, 32'd1);
    check("fetch1_req", {31'd0, imem_req}, 32'd1);
    check("done0_valid", {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'h1456_0000;
    tick();
    check("cap1_opcode", {28'd0, opcode}, 32'd1);
    imem_ready = 1'b0; ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    check("count2", instr_count, 32'd2);

    // Wait states: ready arrives in the 4th request cycle.
    check("wait1_addr", imem_addr, 32'd2);
    tick();
    check("wait2_addr", imem_addr, 32'd2);
    check("wait2_ir", ir, 32'h1456_0000);
    tick();
    check("wait3_addr", imem_addr, 32'd2);
    tick();
    check("wait4_addr", imem_addr, 32'd2);
    check("wait4_valid", {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'h7000_0010;
    tick();
    imem_ready = 1'b0;
    check("wait_cap_ir", ir, 32'h7000_0010);

    // Jump to 0x10.
    ex_done = 1'b1; take_branch = 1'b1; jump_sel = 1'b1;
    tick();
    ex_done = 1'b0; take_branch = 1'b0; jump_sel = 1'b0;
    check("jmp10_addr", imem_addr, 32'h10);

    // Taken branch at 0x10 with imm = -4: 0x11 - 4 = 0x0D.
    imem_ready = 1'b1; imem_rdata = 32'h2000_FFFC;
    tick();
    imem_ready = 1'b0;
    check("br_pc_plus1", pc_plus1, 32'h11);
    check("br_imm", {16'd0, imm}, 32'h0000_FFFC);
    ex_done = 1'b1; take_branch = 1'b1; jump_sel = 1'b0;
    tick();
    ex_done = 1'b0; take_branch = 1'b0;
    check("br_addr", imem_addr, 32'h0D);

    // Not taken, jump_sel high must be ignored.
    imem_ready = 1'b1; imem_rdata = 32'h3000_0000;
    tick();
    imem_ready = 1'b0;
    ex_done = 1'b1; take_branch = 1'b0; jump_sel = 1'b1;
    tick();
    ex_done = 1'b0; jump_sel = 1'b0;
    check("nt_addr", imem_addr, 32'h0E);

    // Absolute jump to 0x40.
    imem_ready = 1'b1; imem_rdata = 32'h7000_0040;
    tick();
    imem_ready = 1'b0;
    ex_done = 1'b1; take_branch = 1'b1; jump_sel = 1'b1;
    tick();
    ex_done = 1'b0; take_branch = 1'b0; jump_sel = 1'b0;
    check("jmp40_addr", imem_addr, 32'h40);
    check("count6", instr_count, 32'd6);

    // Stall in FETCH with spurious ready and ex_done pulses.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ready = ~i[0]; ex_done = i[0]; imem_rdata = 32'hDEAD_BEEF;
      #1;
      check("stall_req", {31'd0, imem_req}, 32'd0);
      tick();
      check("stall_ir", ir, 32'h7000_0040);
      check("stall_pc", pc, 32'h40);
      check("stall_count", instr_count, 32'd6);
      check("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
    stall = 1'b0; imem_ready = 1'b0; ex_done = 1'b0;
    #1;
    check("unstall_req", {31'd0, imem_req}, 32'd1);
    check("unstall_addr", imem_addr, 32'h40);

    // Reset mid-fetch: request must drop immediately.
    reset = 1'b1;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", pc, 32'd0);
    check("midrst_count", instr_count, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    check("midrst_ir", ir, 32'd0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b0;
    reset = 1'b0;
    tick();
    check("rerst_addr", imem_addr, 32'd0);
    check("rerst_ir", ir, 32'd0);

    // Wrap: 8-bit PC starting at 0xFF.
    check("wrap_rst_pc", {24'd0, w_pc}, 32'hFF);
    check("wrap_plus1", {24'd0, w_pc_plus1}, 32'h00);
    w_reset = 1'b0;
    tick();
    check("wrap_req", {31'd0, w_req}, 32'd1);
    check("wrap_addr0", {24'd0, w_addr}, 32'hFF);
    w_ready = 1'b1; w_rdata = 32'h5000_0000;
    tick();
    w_ready = 1'b0; w_ex_done = 1'b1;
    tick();
    w_ex_done = 1'b0;
    check("wrap_addr1", {24'd0, w_addr}, 32'h00);
    check("wrap_count", w_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pierogi CPU, directly upstream of the control unit. It holds the program counter and issues word reads to instruction memory over a req/ready handshake. It latches the returned word into the instruction register and presents the decoded fields (opcode to control; register and immediate fields to the datapath). It advances the PC when execution of the current instruction completes, using control's jump (M13) and branch-taken (M2) selects.

## Interface
- ADDR_W, 32, PC / instruction-memory word-address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  when high, FETCH does not issue a request
- imem_req  out  1  instruction read request
- imem_addr  out  ADDR_W  read word address; equals pc
- imem_ready  in  1  read data valid this cycle; completes the handshake when imem_req=1
- imem_rdata  in  32  instruction word
- ex_done  in  1  one-cycle pulse from control: current instruction finished
- jump_sel  in  1  M13 from control: take jump target
- take_branch  in  1  M2 from control: redirect PC
- pc  out  ADDR_W  address of the instruction in ir
- pc_plus1  out  ADDR_W  pc+1, modulo 2^ADDR_W
- ir  out  32  instruction register
- opcode  out  4  ir[31:28]
- rd / rs / rt  out  4 each  ir[27:24] / ir[23:20] / ir[19:16]
- imm  out  16  ir[15:0]
- instr_valid  out  1  ir holds a fetched, not yet completed instruction
- instr_count  out  32  number of completed instructions, wraps

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE
  - Entered only by reset.
  - Moves unconditionally to FETCH on the next clock edge.
- FETCH
  - imem_req = !stall.
  - imem_addr = pc, stable while imem_req is high.
  - On an edge with imem_req && imem_ready: ir <= imem_rdata, instr_valid <= 1, state -> EXEC.
  - imem_ready while imem_req=0 is ignored.
- EXEC
  - imem_req = 0; ir and pc are held.
  - On an edge with ex_done=1:
    - pc <= next_pc.
    - instr_valid <= 0.
    - instr_count <= instr_count+1.
    - state -> FETCH.
- ex_done is ignored in IDLE and FETCH.
- next_pc, evaluated only on the ex_done edge:
  - If take_branch=1 and jump_sel=1: zero-extend ir[27:0] to ADDR_W (absolute jump).
  - If take_branch=1 and jump_sel=0: pc_plus1 + sign-extend(imm) (beq/bne taken).
  - If take_branch=0: pc_plus1. jump_sel is ignored in this case.
- All PC arithmetic is modulo 2^ADDR_W; pc = all-ones advances to 0.
- Reset values:
  - pc = RESET_PC; ir = 0; instr_valid = 0; imem_req = 0; instr_count = 0; state = IDLE.
  - opcode, rd, rs, rt and imm are 0, because they are derived from ir.
- Reset asserted mid-operation:
  - Takes effect immediately and asynchronously; imem_req drops in the same cycle.
  - Any outstanding read is abandoned; a late imem_ready is ignored because the unit is in IDLE.
- stall rising while imem_req is high
  - The request is withdrawn.
  - Memory must not complete it; ready is sampled only with req.

## Timing
- Fetch
  - imem_req is combinational from state and stall.
  - First request is in the second cycle after reset release (IDLE takes one edge).
  - ready-to-ir latency: 1 edge; instr_valid rises on the same edge that captures ir.
- Minimum instruction period is 2 cycles: 1 FETCH cycle with zero-wait memory, plus the EXEC cycle containing ex_done.
- Each memory wait cycle adds 1 cycle.
- ex_done, jump_sel and take_branch are sampled only on the ex_done edge.
- After that edge, the new pc is on imem_addr in the next cycle, with imem_req high unless stalled.
- Outputs pc, pc_plus1, ir and decoded fields are registered or pure functions of registers; there is no combinational path from imem_rdata to them.

## Test plan
- Reset and sequential fetch:
  - Stimulus: hold reset 3 cycles, release; memory returns 0x4123_0000 at addr 0 and 0x1456_0000 at addr 1, zero wait; pulse ex_done each EXEC.
  - Required: req in cycle 2 with addr 0; opcode=4, rd=1, rs=2, rt=3; then addr 1; instr_count=2.
- Wait states:
  - Stimulus: imem_ready delayed 3 cycles.
  - Required: imem_addr stable for 4 cycles; ir captured only on the ready edge.
- Branch taken:
  - Stimulus: pc=0x10, imm=0xFFFC, take_branch=1, jump_sel=0 at ex_done.
  - Required: next imem_addr=0x0D. With take_branch=0, next addr is 0x11.
- Jump:
  - Stimulus: ir=0x7000_0040, jump_sel=1, take_branch=1.
  - Required: next addr=0x40.
- Stall and spurious inputs:
  - Stimulus: stall high 5 cycles in FETCH; ready pulses while stalled; ex_done pulsed in FETCH.
  - Required: no capture, pc unchanged, instr_count unchanged.
- Reset mid-fetch and wrap:
  - Stimulus: assert reset while imem_req=1.
  - Required: req=0 in the same cycle and all outputs at reset values.
  - Stimulus: with RESET_PC=all-ones, complete 1 instruction.
  - Required: next addr=0.
